// File: rtl/aquarium_mode_scheduler.sv
// Tank-monitor mode sequencer: sweeps the output-mux select through the sweep
// counter and the four sensor modes, strobes each sensor register's load enable,
// range-checks the registered reading and parks in ERROR on an out-of-range value.
module aquarium_mode_scheduler #(
  parameter int unsigned DWELL      = 4,
  parameter logic [7:0]  LOW_LIMIT  = 8'h10,
  parameter logic [7:0]  HIGH_LIMIT = 8'hF0
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       enable,
  input  logic       err_clear,
  input  logic [7:0] q_clean,
  input  logic [7:0] q_temp,
  input  logic [7:0] q_food,
  input  logic [7:0] q_salt,
  output logic [4:0] select,
  output logic [3:0] load_en,
  output logic [7:0] sweep_count,
  output logic       error,
  output logic [3:0] error_src,
  output logic       busy
);

  // State values equal their mux select codes; for sensor states bits [4:1]
  // are the one-hot sensor index used for load_en and error_src.
  typedef enum logic [4:0] {
    IDLE  = 5'b00000,
    COUNT = 5'b00001,
    CLEAN = 5'b00010,
    TEMP  = 5'b00100,
    FOOD  = 5'b01000,
    SALT  = 5'b10000,
    ERROR = 5'b11111
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state, state_n;
  logic [7:0] dwell, dwell_n;
  logic [7:0] count_n;
  logic       error_n;
  logic [3:0] src_n;
  logic [7:0] q_cur;
  logic       is_sensor;
  logic       in_range;

  // Pick the reading belonging to the current sensor mode.
  always_comb begin
    q_cur     = '0;
    is_sensor = 1'b1;
    case (state)
      CLEAN:   q_cur = q_clean;
      TEMP:    q_cur = q_temp;
      FOOD:    q_cur = q_food;
      SALT:    q_cur = q_salt;
      default: is_sensor = 1'b0;
    endcase
    in_range = (q_cur >= LOW_LIMIT) && (q_cur <= HIGH_LIMIT);
  end

  // Next-state, dwell and status computation.
  always_comb begin
    state_n = state;
    dwell_n = dwell;
    count_n = sweep_count;
    error_n = error;
    src_n   = error_src;
    case (state)
      IDLE: begin
        dwell_n = '0;
        if (enable) state_n = COUNT;
      end
      ERROR: begin
        dwell_n = '0;
        if (err_clear) begin
          state_n = IDLE;
          error_n = 1'b0;
          src_n   = '0;
        end
      end
      default: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          // A failed reading beats a pending stop request.
          if (is_sensor && !in_range) begin
            state_n = ERROR;
            error_n = 1'b1;
            src_n   = state[4:1];
          end else begin
            if (state == SALT) count_n = sweep_count + 8'd1;
            if (!enable) begin
              state_n = IDLE;
            end else begin
              case (state)
                COUNT:   state_n = CLEAN;
                CLEAN:   state_n = TEMP;
                TEMP:    state_n = FOOD;
                FOOD:    state_n = SALT;
                default: state_n = COUNT;
              endcase
            end
          end
        end else begin
          dwell_n = dwell + 8'd1;
        end
      end
    endcase
  end

  // State register with registered outputs decoded from the next state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dwell       <= '0;
      select      <= '0;
      load_en     <= '0;
      sweep_count <= '0;
      error       <= 1'b0;
      error_src   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      dwell       <= dwell_n;
      select      <= state_n;
      sweep_count <= count_n;
      error       <= error_n;
      error_src   <= src_n;
      busy        <= (state_n != IDLE);
      // Strobe only on entry into a sensor mode, i.e. its dwell-0 cycle.
      if ((state_n != state) && (state_n != ERROR) && (state_n != IDLE) && (state_n != COUNT))
        load_en <= state_n[4:1];
      else
        load_en <= '0;
    end
  end

endmodule
